// File: rtl/rr_arb_pkg.sv
// Shared constants, state type and index helper for the 4-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Successor index with natural wrap 3 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_prio_enc4.sv
// Rotating-priority encoder: first asserted request at or above ptr, wrapping.
module rr_prio_enc4
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] sel,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ptr + IDX_W'(i);
      if (!any && req[cand]) begin
        sel[cand] = 1'b1;
        sel_idx   = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with held grants and registered outputs.
// Optional grant watchdog compiled in with macro RR_ARB_TIMEOUT_EN.
module rr_arbiter4
  import rr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_arbiter4: TIMEOUT_CYCLES must be within 2..255");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   arb_ptr;
  logic [NUM_REQ-1:0] sel;
  logic [IDX_W-1:0]   sel_idx;
  logic               any;
  logic               owner_rel, force_rel, release_now;

  assign owner_rel = (state_q == GRANT) && (done || !req[idx_q]);

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;

  // done or a dropped request always wins over the watchdog.
  assign force_rel = (state_q == GRANT) && !owner_rel &&
                     (cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
  assign force_rel = 1'b0;
`endif

  assign release_now = owner_rel || force_rel;

  // Re-arbitration in the release cycle already uses the advanced pointer.
  assign arb_ptr = release_now ? next_idx(idx_q) : ptr_q;

  rr_prio_enc4 u_enc (
    .req     (req),
    .ptr     (arb_ptr),
    .sel     (sel),
    .sel_idx (sel_idx),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    if (state_q == IDLE || release_now) begin
      if (release_now) ptr_d = arb_ptr;
      if (any) begin
        state_d = GRANT;
        gnt_d   = sel;
        idx_d   = sel_idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT && !release_now) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= force_rel;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = |gnt_q;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 16, maximum cycles a grant is held before forced release (valid range 2..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req  input  4  per-requester request; bit i = requester i.
REQ-005 SHALL have port: done  input  1  owner releases the shared resource; sampled only while gnt_valid=1.
REQ-006 SHALL have port: gnt  output  4  one-hot grant, registered; all-zero when no owner.
REQ-007 SHALL have port: gnt_idx  output  2  binary index of owner (3->11, 2->10, 1->01, 0->00), registered.
REQ-008 SHALL have port: gnt_valid  output  1  high while any grant is held; equals |gnt.
REQ-009 SHALL have port: timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (one owner held).
REQ-011 SHALL, in IDLE with req!=0, select the first asserted req bit at or above rotating pointer ptr, wrapping 3->0, and enter GRANT on the next edge (latency 1 cycle from req to gnt).
REQ-012 SHALL, in IDLE with req==0, remain in IDLE with gnt=0, gnt_idx unchanged, gnt_valid=0.
REQ-013 SHALL hold gnt, gnt_idx and gnt_valid constant throughout GRANT regardless of other req changes.
REQ-014 SHALL release the grant when done=1, or when req[gnt_idx]=0, whichever occurs first; release takes effect on the next edge.
REQ-015 SHALL, on release, set ptr = gnt_idx + 1 (mod 4) so the releasing owner has lowest priority next.
REQ-016 SHALL, on release with other requests pending, re-arbitrate in the release cycle using the updated ptr and enter GRANT for the new owner on the next edge (no idle bubble).
REQ-017 SHALL, on release with the owner as the only requester, re-grant the same owner on the next edge.
REQ-018 SHALL, on release with req==0 (after masking the releasing owner's done), enter IDLE.
REQ-019 SHALL ignore done while in IDLE.
REQ-020 SHALL never assert more than one gnt bit; gnt_idx SHALL always encode the asserted gnt bit.

Reset
REQ-021 SHALL, on rst_n=0, immediately set state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, ptr=0, timeout counter=0, independent of clk.
REQ-022 SHALL, on reset mid-grant, drop the grant without asserting timeout; first arbitration after deassertion starts from ptr=0.

Configuration
REQ-023 SHALL compile the grant watchdog only when macro RR_ARB_TIMEOUT_EN is defined.
REQ-024 SHALL, with RR_ARB_TIMEOUT_EN, count cycles in GRANT from 0; when count reaches TIMEOUT_CYCLES-1 without done or req drop, force release per REQ-015/016 and pulse timeout for one cycle; count clears on every new grant.
REQ-025 SHALL, with RR_ARB_TIMEOUT_EN, give done priority over timeout in the same cycle (timeout stays 0).
REQ-026 SHALL, without RR_ARB_TIMEOUT_EN, keep the timeout port, drive it constant 0, and implement no counter.

Structure
REQ-027 SHALL take NUM_REQ=4, IDX_W=2 and the state enum (IDLE, GRANT) from shared package rr_arb_pkg.
REQ-028 SHALL place rotating-priority selection in combinational sub-module rr_prio_enc4 (inputs req, ptr; outputs one-hot sel, 2-bit sel_idx, any).

Verification
REQ-029 SHALL cover: reset, then req=0100 -> gnt=0100, gnt_idx=10, gnt_valid=1 one cycle later.
REQ-030 SHALL cover: req=1111 held, done pulsed each grant -> grant order 0,1,2,3,0, gnt_idx 00,01,10,11,00, no idle cycle between grants.
REQ-031 SHALL cover: owner 1 holding, req changes 0010->1011 -> gnt stays 0010 until done; then gnt=1000.
REQ-032 SHALL cover: owner 2 drops req without done, req[0]=1 -> gnt=0001 next cycle, ptr=3 before arbitration.
REQ-033 SHALL cover: RR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, owner never signals done -> timeout=1 for one cycle at 4th grant cycle, grant passes to next requester; without macro timeout stays 0 and grant persists.
REQ-034 SHALL cover: rst_n asserted mid-grant asynchronously -> gnt=0000, gnt_valid=0 before next clk edge; after release req=1001 -> gnt=0001.
